i2s_mic_transmitter: RTL and testbench
======================================

I2S_MIC_TRANSMITTER -- requirements
Module: i2s_mic_transmitter

Interface
REQ-001 Parameter w_sample, default 24: sample width; bits driven MSB-first per active slot.
REQ-002 Parameter w_slot, default 32: SCK periods per WS half-frame; bit counter saturates at w_slot.
REQ-003 Port clk  in  1  system clock, one clock domain; clk frequency SHALL be at least 8x sck frequency.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port sample  in  w_sample  two's-complement sample to transmit.
REQ-006 Port sample_valid  in  1  sample is presented.
REQ-007 Port sample_ready  out  1  holding register empty; transfer occurs when valid && ready at a clk rising edge.
REQ-008 Port lr  in  1  channel select: 0 = transmit while WS low, 1 = transmit while WS high.
REQ-009 Port sck  in  1  I2S bit clock from the external master, asynchronous to clk.
REQ-010 Port ws  in  1  I2S word select from the master, asynchronous, changes on sck falling edges.
REQ-011 Port sd  out  1  serial data, registered.
REQ-012 Port sd_oe  out  1  output enable for sd pad; 0 = high-impedance, registered.
REQ-013 Port underrun  out  1  one-clk pulse when an active slot starts with the holding register empty.

Function
REQ-014 sck and ws SHALL pass through 2-flop synchronizers; edges detected on synchronized sck against a third registered copy.
REQ-015 At each synchronized sck rising edge, ws SHALL be sampled into ws_cur; the previous sampled value is kept as ws_prev.
REQ-016 Slot start: a sck rising edge where ws_known = 1 and ws_cur != ws_prev; ws_known SHALL be set at the first sck rising edge after reset, with no slot start detected at that edge.
REQ-017 At slot start, bit counter SHALL clear to 0 and the slot is active iff ws_cur == lr.
REQ-018 At an active slot start: holding full -> shift register loads holding, holding becomes empty; holding empty -> shift register loads 0 and underrun pulses for 1 clk.
REQ-019 At each synchronized sck falling edge after a slot start: bit index < w_sample in an active slot -> sd = shift MSB, sd_oe = 1, shift left by 1; otherwise sd = 0, sd_oe = 0. Counter then increments, saturating at w_slot.
REQ-020 First falling edge after slot start SHALL drive the sample MSB (one SCK period after WS transition, standard I2S).
REQ-021 sd/sd_oe SHALL update within 4 clk cycles of the pad sck falling edge and otherwise remain stable.
REQ-022 Inactive slot, or no slot start yet seen since reset: sd = 0, sd_oe = 0.
REQ-023 Slot longer than w_slot: counter holds at w_slot, sd_oe stays 0 until the next slot start.
REQ-024 Slot shorter than w_sample (early WS change): new slot start SHALL abort remaining bits; no error flag.
REQ-025 sample_ready = !holding_full && !rst.
REQ-026 Handshake in the same clk as an active-slot-start load with holding empty: underrun pulses, shift register loads 0, new sample SHALL be stored in holding for the next active slot.
REQ-027 lr SHALL be sampled only at slot start; lr changes mid-slot take effect at the next slot start.

Reset
REQ-028 While rst = 1 at a clk edge: sd = 0, sd_oe = 0, underrun = 0, holding empty, shift register = 0, counter = w_slot, ws_known = 0, synchronizers cleared to 0.
REQ-029 Reset mid-slot SHALL drop sd_oe to 0 on the next clk edge; transmission resumes only after a fresh slot start per REQ-016.

Verification
REQ-030 lr = 0, load 24'hA5_C3_F0 before WS falls, sck = 3.125 MHz, clk = 50 MHz -> in WS-low slot sd bits 1010_0101_1100_0011_1111_0000 with sd_oe = 1 for 24 SCK, then sd_oe = 0 for 8 SCK; WS-high slot sd_oe = 0.
REQ-031 lr = 1, load 24'h800001 -> transmitted only in WS-high slot: 1, 22 zeros, 1; no underrun.
REQ-032 No sample loaded, lr = 0 -> underrun pulses exactly once per WS-low slot start, sd = 0 with sd_oe = 1 for 24 bits.
REQ-033 sample_valid held 1 continuously -> exactly one sample accepted per active slot; sample_ready low from accept until next active slot start.
REQ-034 Assert rst for 1 clk at bit 10 of an active slot -> sd_oe = 0 next clk, stays 0 through the rest of that slot and the next WS transition (ws_known re-init), holding empty, sample_ready = 1 after rst deasserts.
REQ-035 Slot of 40 SCK periods -> 24 data bits, then sd_oe = 0 for 16 periods, counter holds at 32; slot of 16 periods -> only the 16 MSBs driven, next slot starts cleanly.

Source files
------------

// File: rtl/i2s_mic_transmitter.sv
// I2S microphone-side transmitter: accepts samples on a valid/ready handshake and
// shifts them out MSB-first on sd during the selected WS slot of an external master.
module i2s_mic_transmitter #(
  parameter int w_sample = 24,
  parameter int w_slot   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [w_sample-1:0] sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                lr,
  input  logic                sck,
  input  logic                ws,
  output logic                sd,
  output logic                sd_oe,
  output logic                underrun
);

  localparam int cw = $clog2(w_slot + 1);
  localparam logic [cw-1:0] cnt_max  = cw'(w_slot);
  localparam logic [cw-1:0] cnt_data = cw'(w_sample);

  logic                sck_s1, sck_s2, sck_s3;
  logic                ws_s1, ws_s2;
  logic                ws_cur, ws_known;
  logic                active;
  logic [cw-1:0]       cnt;
  logic [w_sample-1:0] holding;
  logic                holding_full;
  logic [w_sample-1:0] shift;

  logic sck_rise, sck_fall, slot_start, slot_active_next, accept;

  // ws_cur still holds the previous slot's WS level when the new one is sampled
  assign sck_rise         = sck_s2 & ~sck_s3;
  assign sck_fall         = ~sck_s2 & sck_s3;
  assign slot_start       = sck_rise & ws_known & (ws_s2 != ws_cur);
  assign slot_active_next = (ws_s2 == lr);
  assign sample_ready     = !holding_full && !rst;
  assign accept           = sample_valid && sample_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_s3 <= 1'b0;
      ws_s1  <= 1'b0;
      ws_s2  <= 1'b0;
    end else begin
      sck_s1 <= sck;
      sck_s2 <= sck_s1;
      sck_s3 <= sck_s2;
      ws_s1  <= ws;
      ws_s2  <= ws_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ws_cur   <= 1'b0;
      ws_known <= 1'b0;
      active   <= 1'b0;
    end else if (sck_rise) begin
      ws_cur   <= ws_s2;
      ws_known <= 1'b1;
      if (slot_start) begin
        active <= slot_active_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      holding      <= '0;
      holding_full <= 1'b0;
      shift        <= '0;
      underrun     <= 1'b0;
      sd           <= 1'b0;
      sd_oe        <= 1'b0;
      cnt          <= cnt_max;
    end else begin
      underrun <= 1'b0;
      if (slot_start) begin
        cnt <= '0;
        if (slot_active_next) begin
          if (holding_full) begin
            shift        <= holding;
            holding_full <= 1'b0;
          end else begin
            shift    <= '0;
            underrun <= 1'b1;
          end
        end
      end
      if (sck_fall) begin
        if (active && (cnt < cnt_data)) begin
          sd    <= shift[w_sample-1];
          sd_oe <= 1'b1;
          shift <= {shift[w_sample-2:0], 1'b0};
        end else begin
          sd    <= 1'b0;
          sd_oe <= 1'b0;
        end
        if (cnt != cnt_max) begin
          cnt <= cnt + cw'(1);
        end
      end
      // accept only happens while empty, so it never collides with the unload above
      if (accept) begin
        holding      <= sample;
        holding_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_transmitter.sv
// Directed bench: drives an I2S master (sck 3.125 MHz, clk 50 MHz), logs sd/sd_oe
// once per SCK period and compares each slot against hand-computed words.
module tb_i2s_mic_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        lr = 1'b0;
  logic        sck = 1'b1;
  logic        ws = 1'b1;
  logic        sd, sd_oe, underrun;

  int check_cnt = 0;
  int pass_cnt = 0;
  int underrun_cnt = 0;
  int accept_cnt = 0;
  int log_n = 0;
  logic sd_log [0:1023];
  logic oe_log [0:1023];

  i2s_mic_transmitter #(.w_sample(24), .w_slot(32)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .lr(lr), .sck(sck), .ws(ws),
    .sd(sd), .sd_oe(sd_oe), .underrun(underrun)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (underrun === 1'b1) underrun_cnt <= underrun_cnt + 1;
    if (sample_valid && sample_ready === 1'b1) accept_cnt <= accept_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask

  // Present one sample and hold valid until the handshake completes
  task automatic applyStimulus(input logic [23:0] value);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    sample = value;
    sample_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (sample_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    checkOutput("load_accepted", {31'd0, ok}, 32'd1);
  endtask

  // n SCK periods with ws set at the first falling edge; one log entry per period.
  // If rst_period matches, a sample is pushed then rst pulses after that period's capture.
  task automatic run_half(input logic ws_val, input int n, input int rst_period);
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      if (i == 0) ws = ws_val;
      if (i == rst_period) begin
        sample = 24'h777777;
        sample_valid = 1'b1;
        #20 sample_valid = 1'b0;
        #120;
      end else begin
        #140;
      end
      if (log_n < 1024) begin
        sd_log[log_n] = sd;
        oe_log[log_n] = sd_oe;
        log_n++;
      end
      if (i == rst_period) begin
        checkOutput("ready_full_before_rst", {31'd0, sample_ready}, 32'd0);
        rst = 1'b1;
        #20 rst = 1'b0;
        #1;
        checkOutput("rst_oe", {31'd0, sd_oe}, 32'd0);
        checkOutput("rst_ready", {31'd0, sample_ready}, 32'd1);
        sck = 1'b1;
        #159;
      end else begin
        #20 sck = 1'b1;
        #160;
      end
    end
  endtask

  // Bit j of the slot starting at log index s is driven at the fall of period j+1
  task automatic slot_stats(input int s, input int n, input int n_first,
                            output logic [23:0] data, output int oe_first, output int oe_rest);
    data = '0;
    oe_first = 0;
    oe_rest = 0;
    for (int j = 0; j < n; j++) begin
      if (j < n_first) begin
        data = {data[22:0], sd_log[s + 1 + j]};
        oe_first += int'(oe_log[s + 1 + j]);
      end else begin
        oe_rest += int'(oe_log[s + 1 + j]);
      end
    end
  endtask

  initial begin
    int s_a, s_b, s_c, s_d, s_e, s_g, s_i, s_k, s_m, s_o, s_p, s_q, s_r, s_t, s_v;
    int u0, a0, of, orr;
    logic [23:0] data;

    repeat (4) @(negedge clk);
    checkOutput("rst_sd", {31'd0, sd}, 32'd0);
    checkOutput("rst_sd_oe", {31'd0, sd_oe}, 32'd0);
    checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);
    checkOutput("rst_ready_low", {31'd0, sample_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", {31'd0, sample_ready}, 32'd1);
    repeat (5) @(negedge clk);

    lr = 1'b0;
    applyStimulus(24'hA5C3F0);
    s_a = log_n; run_half(1'b0, 32, -1);
    s_b = log_n; run_half(1'b1, 32, -1);
    lr = 1'b1;
    applyStimulus(24'h800001);
    s_c = log_n; run_half(1'b0, 32, -1);
    slot_stats(s_a, 32, 24, data, of, orr);
    checkOutput("lr0_data", {8'd0, data}, 32'hA5C3F0);
    checkOutput("lr0_oe_data", of, 24);
    checkOutput("lr0_oe_tail", orr, 0);
    slot_stats(s_b, 32, 32, data, of, orr);
    checkOutput("lr0_high_slot_oe", of, 0);
    s_d = log_n; run_half(1'b1, 32, -1);
    s_e = log_n; run_half(1'b0, 32, -1);
    slot_stats(s_c, 32, 32, data, of, orr);
    checkOutput("lr1_low_slot_oe", of, 0);
    slot_stats(s_d, 32, 24, data, of, orr);
    checkOutput("lr1_data", {8'd0, data}, 32'h800001);
    checkOutput("lr1_oe_data", of, 24);
    checkOutput("lr1_oe_tail", orr, 0);
    checkOutput("no_underrun_yet", underrun_cnt, 0);

    lr = 1'b0;
    u0 = underrun_cnt;
    run_half(1'b1, 32, -1);
    s_g = log_n; run_half(1'b0, 32, -1);
    run_half(1'b1, 32, -1);
    s_i = log_n; run_half(1'b0, 32, -1);
    run_half(1'b1, 32, -1);
    checkOutput("underrun_per_low_slot", underrun_cnt - u0, 2);
    slot_stats(s_g, 32, 24, data, of, orr);
    checkOutput("underrun_data_zero", {8'd0, data}, 32'd0);
    checkOutput("underrun_oe", of, 24);
    slot_stats(s_i, 32, 24, data, of, orr);
    checkOutput("underrun_oe_2nd", of, 24);

    u0 = underrun_cnt;
    a0 = accept_cnt;
    sample = 24'h123456;
    sample_valid = 1'b1;
    s_k = log_n; run_half(1'b0, 32, -1);
    run_half(1'b1, 32, -1);
    s_m = log_n; run_half(1'b0, 32, -1);
    run_half(1'b1, 32, -1);
    sample_valid = 1'b0;
    @(negedge clk);
    checkOutput("accepts_per_active_slot", accept_cnt - a0, 3);
    checkOutput("ready_low_while_full", {31'd0, sample_ready}, 32'd0);
    checkOutput("stream_no_underrun", underrun_cnt - u0, 0);
    slot_stats(s_k, 32, 24, data, of, orr);
    checkOutput("stream_data_1", {8'd0, data}, 32'h123456);
    slot_stats(s_m, 32, 24, data, of, orr);
    checkOutput("stream_data_2", {8'd0, data}, 32'h123456);

    u0 = underrun_cnt;
    s_o = log_n; run_half(1'b0, 32, 11);
    s_p = log_n; run_half(1'b1, 32, -1);
    slot_stats(s_o, 32, 11, data, of, orr);
    checkOutput("rst_slot_head", {8'd0, data}, 32'h091);
    checkOutput("rst_slot_oe_head", of, 11);
    checkOutput("rst_slot_oe_after", orr, 0);
    slot_stats(s_p, 32, 32, data, of, orr);
    checkOutput("post_rst_high_oe", of, 0);
    applyStimulus(24'h5A5A5A);
    s_q = log_n; run_half(1'b0, 32, -1);
    run_half(1'b1, 32, -1);
    slot_stats(s_q, 32, 24, data, of, orr);
    checkOutput("resume_data", {8'd0, data}, 32'h5A5A5A);
    checkOutput("resume_oe", of, 24);

    applyStimulus(24'hC0FFEE);
    s_r = log_n; run_half(1'b0, 40, -1);
    run_half(1'b1, 32, -1);
    applyStimulus(24'h9ABCDE);
    s_t = log_n; run_half(1'b0, 16, -1);
    run_half(1'b1, 32, -1);
    applyStimulus(24'h13579B);
    s_v = log_n; run_half(1'b0, 32, -1);
    run_half(1'b1, 32, -1);
    slot_stats(s_r, 40, 24, data, of, orr);
    checkOutput("long_slot_data", {8'd0, data}, 32'hC0FFEE);
    checkOutput("long_slot_oe", of, 24);
    checkOutput("long_slot_tail_oe", orr, 0);
    slot_stats(s_t, 16, 16, data, of, orr);
    checkOutput("short_slot_data", {8'd0, data}, 32'h9ABC);
    checkOutput("short_slot_oe", of, 16);
    slot_stats(s_v, 32, 24, data, of, orr);
    checkOutput("after_short_data", {8'd0, data}, 32'h13579B);
    checkOutput("after_short_oe", of, 24);
    checkOutput("after_short_tail", orr, 0);
    checkOutput("no_underrun_tail", underrun_cnt - u0, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
